// File: rtl/trng_ctrl_pkg.sv
// rtl/trng_ctrl_pkg.sv - shared state encoding, default parameters and width helper for trng_ctrl
//
// Purpose: holds the controller state enumeration, the default values for
// WORD_BITS / SETTLE_CYCLES / REP_LIMIT, and a helper that sizes counters
// from their maximum value.
// Ports: none (package).

package trng_ctrl_pkg;

  localparam int DEF_WORD_BITS     = 32;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_REP_LIMIT     = 31;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_GAP  = 3'd2,
    ST_WAIT = 3'd3,
    ST_FAIL = 3'd4
  } trng_state_e;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/trng_health.sv
// rtl/trng_health.sv - repetition-count health test on the sampled entropy stream
//
// Purpose: counts consecutive identical sampled bits and pulses fail on the
// sample that brings the run length up to REP_LIMIT. The run is tracked
// across word boundaries and only restarts on clear or reset.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   sample       one-cycle strobe: sample_bit is a new sampled bit
//   sample_bit   the sampled bit
//   clear        zero the run counter
//   fail         combinational pulse, valid with sample

module trng_health
  import trng_ctrl_pkg::*;
#(
  parameter int REP_LIMIT = DEF_REP_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic sample,
  input  logic sample_bit,
  input  logic clear,
  output logic fail
);

  localparam int REP_W = cnt_width(REP_LIMIT);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP_LIMIT);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_nxt;
  logic             last_bit;

  // A zero count means no bit has been seen since the last clear, so the
  // first sample always starts a fresh run of one.
  always_comb begin
    rep_nxt = rep_cnt;
    if ((rep_cnt == '0) || (sample_bit != last_bit)) begin
      rep_nxt = REP_W'(1);
    end else if (rep_cnt != REP_MAX) begin
      rep_nxt = rep_cnt + REP_W'(1);
    end
  end

  assign fail = sample && (rep_nxt == REP_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt  <= '0;
      last_bit <= 1'b0;
    end else if (clear) begin
      rep_cnt  <= '0;
    end else if (sample) begin
      rep_cnt  <= rep_nxt;
      last_bit <= sample_bit;
    end
  end

endmodule

// File: rtl/trng_ctrl.sv
// rtl/trng_ctrl.sv - serial TRNG bit collector with word output and repetition health check
//
// Purpose: strobes an external entropy source, samples one bit per
// SETTLE_CYCLES+1 cycle period, packs bits LSB-first into WORD_BITS words and
// hands them out through a one-entry valid/ready holding register. A run of
// REP_LIMIT identical bits latches health_fail until clear_fail.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   enable        1 = collect bits, 0 = stop and discard the partial word
//   clear_fail    pulse that clears health_fail (only acts in FAIL)
//   trng_bit      serial entropy input
//   trng_req      request/power strobe to the source, high only in REQ
//   rd_valid      rd_data holds a complete word
//   rd_ready      consumer takes rd_data this cycle
//   rd_data       collected word, first-sampled bit at LSB
//   health_fail   sticky repetition-count failure

module trng_ctrl
  import trng_ctrl_pkg::*;
#(
  parameter int WORD_BITS     = DEF_WORD_BITS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int REP_LIMIT     = DEF_REP_LIMIT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear_fail,
  input  logic                 trng_bit,
  output logic                 trng_req,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [WORD_BITS-1:0] rd_data,
  output logic                 health_fail
);

  localparam int BIT_W = cnt_width(WORD_BITS - 1);
  localparam int SET_W = cnt_width(SETTLE_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  trng_state_e state;
  trng_state_e state_nxt;

  logic [SET_W-1:0]     settle_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [WORD_BITS-1:0] shift_reg;
  logic [WORD_BITS-1:0] sample_word;

  logic sample;
  logic word_done;
  logic hold_free;
  logic wait_xfer;
  logic flush;
  logic fail_clr;
  logic health_clr;
  logic fail_pulse;

  // New bits enter at the MSB so that after WORD_BITS samples the first one
  // has reached bit 0.
  assign sample_word = {trng_bit, shift_reg[WORD_BITS-1:1]};

  // The holding register can take a word this cycle if it is empty or its
  // current word is being handed over right now.
  assign hold_free = !rd_valid || rd_ready;

  trng_health #(
    .REP_LIMIT (REP_LIMIT)
  ) u_health (
    .clk        (clk),
    .reset      (reset),
    .sample     (sample),
    .sample_bit (trng_bit),
    .clear      (health_clr),
    .fail       (fail_pulse)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (enable && !health_fail) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (sample) begin
          if (fail_pulse)                   state_nxt = ST_FAIL;
          else if (word_done && !hold_free) state_nxt = ST_WAIT;
          else                              state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        state_nxt = enable ? ST_REQ : ST_IDLE;
      end
      ST_WAIT: begin
        if (!enable)        state_nxt = ST_IDLE;
        else if (hold_free) state_nxt = ST_REQ;
      end
      ST_FAIL: begin
        if (clear_fail) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    trng_req   = (state == ST_REQ);
    flush      = (state != ST_FAIL) && !enable;
    fail_clr   = (state == ST_FAIL) && clear_fail;
    health_clr = flush || fail_clr;
    sample     = (state == ST_REQ) && enable && (settle_cnt == SET_LAST);
    word_done  = sample && (bit_cnt == BIT_LAST);
    wait_xfer  = (state == ST_WAIT) && enable && hold_free;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt  <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      health_fail <= 1'b0;
    end else begin
      if ((state == ST_REQ) && enable && !sample) begin
        settle_cnt <= settle_cnt + SET_W'(1);
      end else begin
        settle_cnt <= '0;
      end

      // A health failure wins over a word completing on the same sample:
      // the suspect bits are thrown away.
      if (flush || (sample && fail_pulse)) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (sample) begin
        shift_reg <= sample_word;
        bit_cnt   <= word_done ? '0 : bit_cnt + BIT_W'(1);
      end

      // In WAIT the finished word is parked in shift_reg until the holding
      // register frees up.
      if (word_done && !fail_pulse && hold_free) begin
        rd_data  <= sample_word;
        rd_valid <= 1'b1;
      end else if (wait_xfer) begin
        rd_data  <= shift_reg;
        rd_valid <= 1'b1;
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end

      if (sample && fail_pulse) begin
        health_fail <= 1'b1;
      end else if (fail_clr) begin
        health_fail <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trng_ctrl.sv
// tb/tb_trng_ctrl.sv - directed self-checking bench for trng_ctrl at default parameters

module tb_trng_ctrl;
  import trng_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        clear_fail = 1'b0;
  logic        trng_bit;
  logic        trng_req;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic        health_fail;

  int n_checks = 0;
  int n_errors = 0;

  int mode = 0;
  int smp_cnt = 0;
  int idx_base = 0;
  int req_run = 0;
  logic [31:0] rnd_words [2] = '{32'hA3C51F96, 32'h6B2ED047};

  trng_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clear_fail  (clear_fail),
    .trng_bit    (trng_bit),
    .trng_req    (trng_req),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .health_fail (health_fail)
  );

  always #5 clk = ~clk;

  // Entropy source model: a bit is taken on the 4th consecutive edge with
  // trng_req and enable high, after which the source moves to its next bit.
  always @(posedge clk) begin
    if (reset) begin
      req_run <= 0;
    end else if (trng_req && enable) begin
      if (req_run == 3) begin
        req_run <= 0;
        smp_cnt <= smp_cnt + 1;
      end else begin
        req_run <= req_run + 1;
      end
    end else begin
      req_run <= 0;
    end
  end

  // mode 0: 1,0,1,0...  mode 1: stuck 1  mode 2: fixed pseudo-random words
  // mode 3: 0,1,0,1...
  always_comb begin
    int i;
    logic [31:0] w;
    i = smp_cnt - idx_base;
    w = rnd_words[(i / 32) % 2];
    trng_bit = 1'b0;
    case (mode)
      0: trng_bit = ~i[0];
      1: trng_bit = 1'b1;
      2: trng_bit = w[i % 32];
      3: trng_bit = i[0];
      default: trng_bit = 1'b0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!rd_valid && n < max) begin
      step();
      n++;
    end
  endtask

  task automatic restart(input int m);
    idx_base = smp_cnt;
    mode = m;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    enable = 1'b0;
    clear_fail = 1'b0;
    rd_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int m;
    int n;
    int changes;

    // Reset state, then alternating bits with an always-ready consumer.
    apply_reset();
    check("rst_req", trng_req, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_fail", health_fail, 0);
    check("rst_state", dut.state, ST_IDLE);

    restart(0);
    rd_ready = 1'b1;
    enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("req_pat%0d", k), trng_req, ((k - 1) % 5) != 4);
    end
    wait_valid(400, m);
    check("lat1", 10 + m + 1, 161);
    check("data1", rd_data, 32'h55555555);
    step();
    check("drop1", rd_valid, 0);

    // Back-pressure: first word held, controller parks in WAIT.
    apply_reset();
    restart(2);
    enable = 1'b1;
    wait_valid(400, m);
    check("lat2", m + 1, 161);
    check("w0", rd_data, 32'hA3C51F96);
    changes = 0;
    repeat (170) begin
      step();
      if (rd_data !== 32'hA3C51F96 || rd_valid !== 1'b1) changes++;
    end
    check("hold_stable", changes, 0);
    check("wait_req", trng_req, 0);
    check("wait_state", dut.state, ST_WAIT);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("w1", rd_data, 32'h6B2ED047);
    check("w1_valid", rd_valid, 1);
    check("resume_req", trng_req, 1);

    // Stuck-at-1 source trips the repetition test on the 31st sample.
    apply_reset();
    restart(1);
    rd_ready = 1'b1;
    enable = 1'b1;
    n = 0;
    while (!health_fail && n < 300) begin
      step();
      n++;
    end
    check("fail_at", n, 155);
    check("fail_req", trng_req, 0);
    check("fail_valid", rd_valid, 0);
    repeat (20) step();
    check("fail_sticky", health_fail, 1);
    check("fail_req_hold", trng_req, 0);
    restart(0);
    clear_fail = 1'b1;
    step();
    clear_fail = 1'b0;
    check("clr_fail", health_fail, 0);
    check("clr_state", dut.state, ST_IDLE);
    wait_valid(400, m);
    check("lat3", m + 1, 161);
    check("data3", rd_data, 32'h55555555);

    // Disable after ten bits, re-enable with the opposite phase; a stray
    // clear_fail outside FAIL must change nothing.
    apply_reset();
    restart(0);
    rd_ready = 1'b1;
    enable = 1'b1;
    repeat (50) step();
    enable = 1'b0;
    step();
    check("dis_req", trng_req, 0);
    check("dis_state", dut.state, ST_IDLE);
    check("dis_valid", rd_valid, 0);
    repeat (3) step();
    restart(3);
    enable = 1'b1;
    n = 0;
    while (!rd_valid && n < 400) begin
      step();
      n++;
      clear_fail = (n == 20);
    end
    clear_fail = 1'b0;
    check("lat4", n + 1, 161);
    check("data4", rd_data, 32'hAAAAAAAA);
    check("nofail4", health_fail, 0);

    // Asynchronous reset mid-word and during WAIT.
    apply_reset();
    restart(0);
    enable = 1'b1;
    repeat (72) step();
    check("pre_rst_req", trng_req, 1);
    #1 reset = 1'b1;
    #1;
    check("arst_req", trng_req, 0);
    check("arst_state", dut.state, ST_IDLE);
    step();
    reset = 1'b0;
    restart(0);
    wait_valid(400, m);
    check("lat5", m + 1, 161);
    check("data5", rd_data, 32'h55555555);
    repeat (170) step();
    check("wait5", dut.state, ST_WAIT);
    #1 reset = 1'b1;
    #1;
    check("arst_valid", rd_valid, 0);
    check("arst_data", rd_data, 0);
    check("arst_req2", trng_req, 0);
    check("arst_fail", health_fail, 0);
    step();
    reset = 1'b0;
    restart(0);
    rd_ready = 1'b1;
    wait_valid(400, m);
    check("lat6", m + 1, 161);
    check("data6", rd_data, 32'h55555555);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
